// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, memop codes
// and address-source select values.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IF_ACC = 2'd1;
    localparam logic [1:0] ST_D_ACC  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [2:0] MEMOP_B  = 3'b001;
    localparam logic [2:0] MEMOP_H  = 3'b010;
    localparam logic [2:0] MEMOP_W  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic ADDRSRC_INSTR = 1'b0;
    localparam logic ADDRSRC_DATA  = 1'b1;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant select for fetch vs data, with starvation counting (default) or
// round-robin fairness when MEM_ARB_RR_EN is defined.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

`ifdef MEM_ARB_RR_EN
    // last_d_q = 1 means data won the most recent grant; fetch is the reset winner.
    logic last_d_q, last_d_d;

    always_comb begin
        grant_if = arb_en && if_req && (!d_req || last_d_q);
        grant_d  = arb_en && d_req && !grant_if;
        last_d_d = last_d_q;
        if (grant_if) begin
            last_d_d = 1'b0;
        end else if (grant_d) begin
            last_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_BURST);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                starve_hit;

    always_comb begin
        starve_hit   = (starve_cnt_q == STARVE_MAX);
        grant_if     = arb_en && if_req && (!d_req || starve_hit);
        grant_d      = arb_en && d_req && !grant_if;
        starve_cnt_d = starve_cnt_q;
        // A data grant reaching the else-branch implies if_req is pending.
        if (grant_if || (arb_en && !if_req)) begin
            starve_cnt_d = '0;
        end else if (grant_d && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// Build option MEM_ARB_RR_EN selects round-robin instead of data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_memop,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic              mem_addrsrc,
    output logic [2:0]        mem_memop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        memop_q, memop_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_if, grant_d;

    mem_arb_grant #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_grant (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (state_q == ST_IDLE),
        .if_req  (if_req),
        .d_req   (d_req),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        memop_d    = memop_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    addr_d  = d_addr;
                    memop_d = d_memop;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ST_D_ACC;
                end else if (grant_if) begin
                    addr_d  = if_addr;
                    memop_d = MEMOP_W;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ST_IF_ACC;
                end
            end
            ST_IF_ACC: begin
                if_rdata_d = mem_rd;
                if_ready_d = 1'b1;
                state_d    = ST_RESP;
            end
            ST_D_ACC: begin
                if (!we_q) begin
                    d_rdata_d = mem_rd;
                end
                d_ready_d = 1'b1;
                state_d   = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory drive decodes from registered state only, so reset drops mem_we at once.
    always_comb begin
        mem_we      = 1'b0;
        mem_addrsrc = ADDRSRC_INSTR;
        mem_memop   = '0;
        mem_addr    = '0;
        mem_wd      = '0;
        case (state_q)
            ST_IF_ACC: begin
                mem_addr  = addr_q;
                mem_memop = MEMOP_W;
            end
            ST_D_ACC: begin
                mem_addr    = addr_q;
                mem_memop   = memop_q;
                mem_wd      = wdata_q;
                mem_addrsrc = ADDRSRC_DATA;
                mem_we      = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            memop_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            memop_q    <= memop_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed vectors.
module tb_mem_arbiter;

    localparam int MAXB = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_memop = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic        mem_addrsrc;
    logic [2:0]  mem_memop;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Read-only memory contents as a function of byte address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h08:  return 32'hDEAD_BEEF;
            32'h0C:  return 32'h1234_5678;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign mem_rd = memf(mem_addr);

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_memop(d_memop), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addrsrc(mem_addrsrc), .mem_memop(mem_memop),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: each access spans grant cycle, memory cycle, response cycle.
    int          cyc_since_grant = 0;   // 0: free to arbitrate, 1: memory cycle, 2: response
    bit          cur_d = 0, cur_we = 0;
    logic [31:0] cur_addr = '0, cur_wd = '0;
    logic [2:0]  cur_op = '0;
    logic [31:0] e_if_rd = '0, e_d_rd = '0;
    bit          e_if_rdy = 0, e_d_rdy = 0;
    int          data_wins_while_fetch_waits = 0;
    bit          last_was_data = 0;
    bit          take_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_since_grant = 0;
            cur_d = 0; cur_we = 0; cur_addr = '0; cur_wd = '0; cur_op = '0;
            e_if_rd = '0; e_d_rd = '0; e_if_rdy = 0; e_d_rdy = 0;
            data_wins_while_fetch_waits = 0;
            last_was_data = 0;
        end else begin
            e_if_rdy = 0;
            e_d_rdy  = 0;
            if (cyc_since_grant == 0) begin
                if (!if_req) data_wins_while_fetch_waits = 0;
                if (d_req && if_req)
                    take_d = RR ? !last_was_data : (data_wins_while_fetch_waits < MAXB);
                else
                    take_d = d_req;
                if (d_req || if_req) begin
                    if (take_d) begin
                        cur_d = 1; cur_we = d_we; cur_addr = d_addr; cur_op = d_memop; cur_wd = d_wdata;
                        if (if_req && data_wins_while_fetch_waits < MAXB)
                            data_wins_while_fetch_waits++;
                        last_was_data = 1;
                    end else begin
                        cur_d = 0; cur_we = 0; cur_addr = if_addr; cur_op = 3'b011; cur_wd = '0;
                        data_wins_while_fetch_waits = 0;
                        last_was_data = 0;
                    end
                    cyc_since_grant = 1;
                end
            end else if (cyc_since_grant == 1) begin
                if (cur_d) begin
                    if (!cur_we) e_d_rd = memf(cur_addr);
                    e_d_rdy = 1;
                end else begin
                    e_if_rd = memf(cur_addr);
                    e_if_rdy = 1;
                end
                cyc_since_grant = 2;
            end else begin
                cyc_since_grant = 0;
            end
        end
    end

    bit checking = 0;

    always @(negedge clk) begin
        if (checking) begin
            bit mc;
            mc = (cyc_since_grant == 1) && !reset;
            check("mem_we",      mem_we,      (mc && cur_d && cur_we) ? 1 : 0);
            check("mem_addrsrc", mem_addrsrc, (mc && cur_d) ? 1 : 0);
            check("mem_memop",   mem_memop,   mc ? cur_op : 3'b000);
            check("mem_addr",    mem_addr,    mc ? cur_addr : 32'h0);
            check("mem_wd",      mem_wd,      mc ? cur_wd : 32'h0);
            check("if_ready",    if_ready,    e_if_rdy);
            check("d_ready",     d_ready,     e_d_rdy);
            check("if_rdata",    if_rdata,    e_if_rd);
            check("d_rdata",     d_rdata,     e_d_rd);
        end
    end

    string seq;
    string exp_seq;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checking = 1;
        check("rst_if_ready", if_ready, 0);
        check("rst_d_ready",  d_ready,  0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata",  d_rdata,  0);
        check("rst_mem_we",   mem_we,   0);
        #1 reset = 1'b0;

        // Fetch alone
        @(negedge clk); #1;
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check("f_addrsrc", mem_addrsrc, 0);
        check("f_memop",   mem_memop,   3'b011);
        check("f_addr",    mem_addr,    32'h10);
        check("f_ready_c1", if_ready,   0);
        @(negedge clk);
        check("f_ready_c2", if_ready, 1);
        check("f_rdata",    if_rdata, 32'h0050_0093);
        #1 if_req = 0;
        @(negedge clk);
        check("f_ready_drop", if_ready, 0);

        // Byte store
        #1 d_req = 1; d_we = 1; d_memop = 3'b001; d_addr = 32'h3; d_wdata = 32'hAB;
        @(negedge clk);
        check("s_we",      mem_we,      1);
        check("s_addrsrc", mem_addrsrc, 1);
        check("s_addr",    mem_addr,    32'h3);
        check("s_wd",      mem_wd,      32'hAB);
        @(negedge clk);
        check("s_we_off", mem_we,  0);
        check("s_ready",  d_ready, 1);
        #1 d_req = 0; d_we = 0;
        @(negedge clk);
        check("s_ready_drop", d_ready, 0);

        // Load with address changed mid-access
        #1 d_req = 1; d_we = 0; d_memop = 3'b011; d_addr = 32'h8;
        @(negedge clk);
        #1 d_addr = 32'hC;
        #1 check("l_addr_held", mem_addr, 32'h8);
        @(negedge clk);
        check("l_ready", d_ready, 1);
        check("l_rdata", d_rdata, 32'hDEAD_BEEF);
        #1 d_req = 0;
        @(negedge clk);

        // Reset during a store's memory cycle
        #1 d_req = 1; d_we = 1; d_memop = 3'b011; d_addr = 32'h20; d_wdata = 32'h55;
        @(negedge clk);
        check("r_we_before", mem_we, 1);
        #1 reset = 1;
        #1 check("r_we_async", mem_we, 0);
        @(negedge clk);
        check("r_d_ready",  d_ready,  0);
        check("r_d_rdata",  d_rdata,  0);
        check("r_if_rdata", if_rdata, 0);
        #1 d_req = 0; d_we = 0; reset = 0;
        @(negedge clk);
        check("r_d_ready_after", d_ready, 0);

        // Both requesters held high
        #1 if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_memop = 3'b011; d_addr = 32'h80;
        seq = "";
        for (int c = 0; c < 200 && seq.len() < 10; c++) begin
            @(negedge clk);
            if (if_ready) seq = {seq, "F"};
            if (d_ready)  seq = {seq, "D"};
        end
        #1 if_req = 0; d_req = 0;
        exp_seq = RR ? "DFDFDFDFDF" : "DDDDFDDDDF";
        n_tests++;
        if (seq != exp_seq) begin
            n_fail++;
            $display("FAIL grant_order: got %s expected %s", seq, exp_seq);
        end
        repeat (3) @(negedge clk);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single-port unified instruction/data memory between two requesters: the instruction-fetch port and the load/store data port of the multicycle RISC-V core. Each access is registered through a small FSM. The arbiter drives the memory's we/AddrSrc/MemOp/addr/wd inputs and returns captured read data with a one-cycle ready pulse. Data accesses have priority over fetch, and a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, requester and memory address width
DATA_W, 32, data width
MAX_DATA_BURST, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  ADDR_W  fetch byte address
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched word, registered
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load
d_memop  in  3  size/sign code: 001 byte, 010 half, 011 word, 100 byte-unsigned, 101 half-unsigned
d_addr  in  ADDR_W  data byte address, segment-relative
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load result, registered
mem_we  out  1  memory write enable
mem_addrsrc  out  1  1 = data segment access, 0 = instruction access
mem_memop  out  3  memory size/sign code
mem_addr  out  ADDR_W  memory byte address
mem_wd  out  DATA_W  memory write data
mem_rd  in  DATA_W  combinational memory read data

Behaviour:
- Clock is clk. Reset is asynchronous and active-high.
- On reset:
  - State goes to IDLE.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - Latched request registers are cleared.
  - Starvation counter is 0.
  - mem_we=0 immediately, without waiting for a clock edge.
- States: IDLE, IF_ACC, D_ACC, RESP.
- IDLE:
  - Memory outputs: mem_we=0, all other memory outputs 0.
  - Grant rule: d_req wins, unless if_req && starve_cnt==MAX_DATA_BURST, in which case fetch wins. Otherwise if_req alone wins.
  - On a grant, the winner's addr/memop/we/wdata are latched and the FSM moves to IF_ACC or D_ACC.
  - With no request, stay in IDLE.
- IF_ACC:
  - Drives mem_addr=latched addr, mem_memop=011, mem_addrsrc=0, mem_we=0.
  - At the closing edge: if_rdata<=mem_rd, if_ready<=1, go to RESP.
- D_ACC:
  - Drives latched addr, memop and wdata, mem_addrsrc=1, mem_we=latched d_we.
  - At the closing edge: d_rdata<=mem_rd for a load; for a store d_rdata holds its value. d_ready<=1, go to RESP.
- RESP:
  - Ready is high for exactly this one cycle. No arbitration happens and mem_we=0.
  - Next cycle returns to IDLE.
  - A requester may drop or re-raise req in the RESP cycle; only the IDLE sample counts.
- Latency: req sampled in IDLE at cycle 0 → memory driven in cycle 1 → ready in cycle 2. Throughput is one access per 3 cycles.
- Starvation counter:
  - Increments on each data grant made while if_req=1, saturating at MAX_DATA_BURST.
  - Clears on every fetch grant, and on any IDLE cycle in which if_req=0.
- Latched request fields are stable for the whole ACC state. Requester inputs changing mid-access have no effect.
- If req drops before ready (a protocol violation), the access still completes and ready still pulses.
- Addresses and memop pass through unmodified. No alignment checking. Segment offsetting is done by the memory.
- Reset asserted in IF_ACC/D_ACC aborts the access: no ready pulse, and mem_we drops asynchronously.

Optional Feature:
MEM_ARB_RR_EN
- Defined: fixed priority is replaced by round-robin. A last_grant flop (reset value: fetch) gives the other requester priority on simultaneous requests. The starvation counter and MAX_DATA_BURST are unused.
- Undefined: data priority with the starvation counter, as above.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding (IDLE=2'd0, IF_ACC=2'd1, D_ACC=2'd2, RESP=2'd3).
  - Memop constants MEMOP_B=3'b001, MEMOP_H=3'b010, MEMOP_W=3'b011, MEMOP_BU=3'b100, MEMOP_HU=3'b101.
  - Constants ADDRSRC_INSTR=0, ADDRSRC_DATA=1.
- One sub-module is natural: mem_arb_grant, the combinational grant select plus starvation/round-robin bookkeeping. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset pulse mid-D_ACC with d_we=1 → mem_we falls within the same cycle; no d_ready pulse; state IDLE; rdata outputs 0.
- if_req alone, if_addr=0x10, mem_rd=0x00500093 → mem_addrsrc=0, mem_memop=011 in cycle 1; if_ready pulse in cycle 2; if_rdata=0x00500093.
- Store: d_req, d_we=1, d_memop=001, d_addr=0x3, d_wdata=0xAB → mem_we=1 for exactly one cycle with mem_addrsrc=1, mem_addr=0x3, mem_wd=0xAB; d_ready in cycle 2.
- if_req and d_req both held high continuously, MAX_DATA_BURST=4 → grant order D,D,D,D,F,D,D,D,D,F; each ready is a single-cycle pulse.
- Requester changes d_addr 0x8→0xC during D_ACC → mem_addr stays 0x8; d_rdata=mem_rd captured at address 0x8.
- MEM_ARB_RR_EN defined, both requests held high → grants alternate F,D,F,D starting with D (last_grant resets to fetch); starvation counter inactive.
